// File: rtl/usb_bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// usb_bus_sequencer_if
//
// Purpose: bundles the Avalon-MM slave port and the USB controller chip pins
// of usb_bus_sequencer into a single interface.
//
// Signal summary:
//   Avalon side : address[1:0], chipselect, write_n, read_n, writedata[31:0]
//                 (into the sequencer), readdata[31:0] (out of the sequencer)
//   USB chip    : usb_cs_n, usb_wr_n, usb_rd_n, usb_a0, usb_data_out[7:0],
//                 usb_data_oe (out of the sequencer), usb_data_in[7:0],
//                 usb_int_n (into the sequencer)
//
// Modports:
//   slave  - the sequencer's view
//   master - the environment's view (CPU interconnect plus chip model)
// ---------------------------------------------------------------------------
interface usb_bus_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    logic        usb_cs_n;
    logic        usb_wr_n;
    logic        usb_rd_n;
    logic        usb_a0;
    logic [7:0]  usb_data_out;
    logic        usb_data_oe;
    logic [7:0]  usb_data_in;
    logic        usb_int_n;

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        input  usb_data_in, usb_int_n,
        output readdata,
        output usb_cs_n, usb_wr_n, usb_rd_n, usb_a0, usb_data_out, usb_data_oe
    );

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        output usb_data_in, usb_int_n,
        input  readdata,
        input  usb_cs_n, usb_wr_n, usb_rd_n, usb_a0, usb_data_out, usb_data_oe
    );
endinterface

// File: rtl/usb_bus_sequencer.sv
// ---------------------------------------------------------------------------
// usb_bus_sequencer
//
// Purpose: Avalon-MM slave that runs one complete parallel-bus cycle
// (CS#, WR#/RD#, A0, 8-bit data) on the external USB controller chip per
// register access, with programmable setup / strobe / hold lengths, and
// captures the read byte at the end of a read strobe.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - usb_bus_sequencer_if.slave (Avalon register port + chip pins)
//
// Register map (address):
//   0 wr: write cycle, a0=0, data=writedata[7:0]   rd: captured byte
//   1 wr: write cycle, a0=1, data=writedata[7:0]   rd: captured byte
//   2 wr: read cycle,  a0=writedata[0]             rd: {int, overrun, busy}
//   3 rw: timing config {hold[11:8], pulse[7:4], setup[3:0]}, 0 acts as 1
// ---------------------------------------------------------------------------
module usb_bus_sequencer #(
    parameter logic [3:0] SETUP_DEF = 4'd2,
    parameter logic [3:0] PULSE_DEF = 4'd4,
    parameter logic [3:0] HOLD_DEF  = 4'd2
) (
    input  logic               clk,
    input  logic               reset,
    usb_bus_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [11:0] r_cfg;
    logic [3:0]  w_eff [3];        // effective setup/pulse/hold (0 -> 1)

    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [3:0]  r_pulse;          // counts latched when the cycle starts
    logic [3:0]  r_hold;
    logic        r_is_read;
    logic        w_is_read_next;
    logic        r_a0;
    logic [7:0]  r_data;
    logic [7:0]  r_rdata;
    logic        r_overrun;
    logic        r_int_meta;
    logic        r_int_sync;

    logic        r_cs_n;
    logic        r_wr_n;
    logic        r_rd_n;
    logic        r_oe;
    logic        w_cs_n_next;
    logic        w_wr_n_next;
    logic        w_rd_n_next;
    logic        w_oe_next;

    logic        w_busy;
    logic        w_wr_access;
    logic        w_start;
    logic        w_accept;
    logic        w_cfg_wr;
    logic        w_stat_rd;
    logic        w_capture;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_busy      = (r_state != ST_IDLE);
    assign w_wr_access = bus.chipselect && !bus.write_n;
    assign w_start     = w_wr_access && (bus.address != 2'd3);
    assign w_accept    = w_start && !w_busy;
    assign w_cfg_wr    = w_wr_access && (bus.address == 2'd3);
    assign w_stat_rd   = bus.chipselect && !bus.read_n && (bus.address == 2'd2);

    assign w_unused    = ^bus.writedata[31:12];

    // A programmed count of zero behaves as a single cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi = gi + 1) begin : g_eff
            assign w_eff[gi] = (r_cfg[gi*4 +: 4] == 4'd0) ? 4'd1 : r_cfg[gi*4 +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state, phase counter and next pin values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_capture      = 1'b0;
        w_is_read_next = r_is_read;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next   = ST_SETUP;
                    w_cnt_next     = w_eff[0];
                    w_is_read_next = (bus.address == 2'd2);
                end
            end
            ST_SETUP: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_STROBE;
                    w_cnt_next   = r_pulse;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = r_hold;
                    w_capture    = r_is_read;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase

        // Pins are decoded from the next state and registered, so they
        // change only on clock edges and never glitch.
        w_cs_n_next = (w_state_next == ST_IDLE);
        w_wr_n_next = !((w_state_next == ST_STROBE) && !w_is_read_next);
        w_rd_n_next = !((w_state_next == ST_STROBE) &&  w_is_read_next);
        w_oe_next   = (w_state_next != ST_IDLE) && !w_is_read_next;
    end

    // ------------------------------------------------------------------
    // Datapath, status and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 4'd0;
            r_pulse    <= 4'd1;
            r_hold     <= 4'd1;
            r_is_read  <= 1'b0;
            r_a0       <= 1'b0;
            r_data     <= 8'h00;
            r_rdata    <= 8'h00;
            r_overrun  <= 1'b0;
            r_cfg      <= {HOLD_DEF, PULSE_DEF, SETUP_DEF};
            r_int_meta <= 1'b1;
            r_int_sync <= 1'b1;
            r_cs_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_oe       <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_is_read <= w_is_read_next;

            // The running cycle keeps the lengths it started with even if
            // the config register is rewritten while busy.
            if (w_accept) begin
                r_pulse <= w_eff[1];
                r_hold  <= w_eff[2];
                r_a0    <= (bus.address == 2'd2) ? bus.writedata[0] : bus.address[0];
                r_data  <= bus.writedata[7:0];
            end

            if (w_capture) begin
                r_rdata <= bus.usb_data_in;
            end

            // Setting overrun takes priority over the read-clear.
            if (w_start && w_busy) begin
                r_overrun <= 1'b1;
            end else if (w_stat_rd) begin
                r_overrun <= 1'b0;
            end

            if (w_cfg_wr) begin
                r_cfg <= bus.writedata[11:0];
            end

            r_int_meta <= bus.usb_int_n;
            r_int_sync <= r_int_meta;

            r_cs_n <= w_cs_n_next;
            r_wr_n <= w_wr_n_next;
            r_rd_n <= w_rd_n_next;
            r_oe   <= w_oe_next;
        end
    end

    // ------------------------------------------------------------------
    // Zero-wait-state read mux
    // ------------------------------------------------------------------
    always_comb begin
        bus.readdata = 32'h0;
        case (bus.address)
            2'd0, 2'd1: bus.readdata = {24'h0, r_rdata};
            2'd2:       bus.readdata = {29'h0, !r_int_sync, r_overrun, w_busy};
            default:    bus.readdata = {20'h0, r_cfg};
        endcase
    end

    assign bus.usb_cs_n     = r_cs_n;
    assign bus.usb_wr_n     = r_wr_n;
    assign bus.usb_rd_n     = r_rd_n;
    assign bus.usb_a0       = r_a0;
    assign bus.usb_data_out = r_data;
    assign bus.usb_data_oe  = r_oe;

endmodule
